// File: rtl/data_upload.sv
// SPI-driven upload engine: the io controller selects a file upload and clocks RAM
// bytes out over sdo, with a one-byte read prefetch running on the system clock.
module data_upload #(
  parameter logic [24:0] BASE   = 25'h200000,
  parameter int unsigned RD_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sck,
  input  logic        ss,
  input  logic        sdi,
  output logic        sdo,
  input  logic [24:0] size,
  output logic        uploading,
  output logic [4:0]  index,
  output logic        rd,
  output logic [24:0] a,
  input  logic [7:0]  d
);

  typedef enum logic [7:0] {
    CMD_FILE_INDEX  = 8'h55,
    CMD_FILE_RX     = 8'h56,
    CMD_FILE_RX_DAT = 8'h57
  } cmd_e;

  logic [2:0] sck_sync_q;
  logic [1:0] ss_sync_q, sdi_sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync_q <= '0;
      ss_sync_q  <= '1;
      sdi_sync_q <= '0;
    end else begin
      sck_sync_q <= {sck_sync_q[1:0], sck};
      ss_sync_q  <= {ss_sync_q[0], ss};
      sdi_sync_q <= {sdi_sync_q[0], sdi};
    end
  end

  logic       ss_s, sdi_s, sck_rise, sck_fall;
  logic [7:0] rx_byte;

  assign ss_s     = ss_sync_q[1];
  assign sdi_s    = sdi_sync_q[1];
  assign sck_rise =  sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] &  sck_sync_q[2];

  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        sr_q, sr_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [4:0]        index_q, index_d;
  logic              up_q, up_d;
  logic [24:0]       addr_q, addr_d;
  logic [24:0]       len_q, len_d;
  logic [24:0]       sent_q, sent_d;
  logic [7:0]        txsr_q, txsr_d;
  logic [7:0]        pbuf_q, pbuf_d;
  logic              rd_q, rd_d;
  logic              pf_req_q, pf_req_d;
  logic [RD_LAT-1:0] lat_q, lat_d;

  assign rx_byte = {sr_q[6:0], sdi_s};

  always_comb begin
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    cmd_d    = cmd_q;
    index_d  = index_q;
    up_d     = up_q;
    addr_d   = addr_q;
    len_d    = len_q;
    sent_d   = sent_q;
    txsr_d   = txsr_q;
    pbuf_d   = pbuf_q;
    rd_d     = pf_req_q;
    pf_req_d = 1'b0;

    lat_d[0] = rd_q;
    for (int unsigned i = 1; i < RD_LAT; i++) lat_d[i] = lat_q[i-1];
    if (lat_q[RD_LAT-1]) pbuf_d = d;

    if (ss_s) begin
      cnt_d = '0;
    end else if (sck_rise) begin
      sr_d  = rx_byte;
      cnt_d = (cnt_q == 4'd15) ? 4'd8 : cnt_q + 4'd1;
      if (cnt_q == 4'd7) cmd_d = rx_byte;
      if (cnt_q == 4'd15) begin
        case (cmd_q)
          CMD_FILE_INDEX: index_d = rx_byte[4:0];
          CMD_FILE_RX: begin
            if (rx_byte[0]) begin
              up_d     = 1'b1;
              addr_d   = BASE;
              len_d    = size;
              sent_d   = '0;
              pf_req_d = (size != '0);
            end else begin
              up_d = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end

    if (sck_fall) begin
      if (cnt_q == 4'd8 && cmd_q == CMD_FILE_RX_DAT && up_q) begin
        if (sent_q < len_q) begin
          txsr_d   = pbuf_q;
          sent_d   = sent_q + 25'd1;
          addr_d   = addr_q + 25'd1;
          // the byte just loaded was already prefetched, so only read ahead while more remain
          pf_req_d = (sent_d < len_q);
        end else begin
          txsr_d = '0;
        end
      end else begin
        txsr_d = {txsr_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      sr_q     <= '0;
      cmd_q    <= '0;
      index_q  <= '0;
      up_q     <= 1'b0;
      addr_q   <= BASE;
      len_q    <= '0;
      sent_q   <= '0;
      txsr_q   <= '0;
      pbuf_q   <= '0;
      rd_q     <= 1'b0;
      pf_req_q <= 1'b0;
      lat_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      cmd_q    <= cmd_d;
      index_q  <= index_d;
      up_q     <= up_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      sent_q   <= sent_d;
      txsr_q   <= txsr_d;
      pbuf_q   <= pbuf_d;
      rd_q     <= rd_d;
      pf_req_q <= pf_req_d;
      lat_q    <= lat_d;
    end
  end

  assign sdo       = ~ss_s & txsr_q[7];
  assign uploading = up_q;
  assign index     = index_q;
  assign rd        = rd_q;
  assign a         = addr_q;

endmodule

// File: tb/tb_data_upload.sv
// Directed bench for data_upload: SPI master task, RAM model with fixed read latency,
// hand-computed expected bytes and read counts.
module tb_data_upload;

  localparam logic [24:0] BASE   = 25'h200000;
  localparam int unsigned RD_LAT = 2;

  logic        clk = 1'b0;
  logic        reset, sck, ss, sdi, sdo, uploading, rd;
  logic [24:0] size, a;
  logic [4:0]  index;
  logic [7:0]  d = 8'hEE;

  data_upload #(.BASE(BASE), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .sck(sck), .ss(ss), .sdi(sdi), .sdo(sdo),
    .size(size), .uploading(uploading), .index(index), .rd(rd), .a(a), .d(d)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [24:0] ad);
    logic [24:0] off;
    off = ad - BASE;
    case (off)
      25'd0:   return 8'hA1;
      25'd1:   return 8'hB2;
      25'd2:   return 8'hC3;
      default: return 8'h77;
    endcase
  endfunction

  // RAM model: d carries valid data only during the RD_LAT-th cycle after rd
  int          cyc = 0;
  int          rd_count = 0;
  logic [24:0] rd_addrs [0:63];
  logic        pend_v = 1'b0;
  logic [24:0] pend_addr;
  int          pend_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    d = 8'hEE;
    if (pend_v && cyc == pend_cyc) begin
      check_eq("a_hold", {7'd0, a}, {7'd0, pend_addr});
      d = mem_byte(pend_addr);
      pend_v = 1'b0;
    end
    if (rd === 1'b1) begin
      if (rd_count < 64) rd_addrs[rd_count] = a;
      rd_count++;
      pend_v    = 1'b1;
      pend_addr = a;
      pend_cyc  = cyc + RD_LAT;
    end
  end

  logic [7:0] tx_buf [0:7];
  logic [7:0] rx_buf [0:7];

  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      sdi = tx[7-i];
      #80;
      rx[7-i] = sdo;
      sck = 1'b1;
      #80;
      sck = 1'b0;
    end
  endtask

  task automatic spi_txn(input int n);
    ss = 1'b0;
    #40;
    for (int k = 0; k < n; k++) spi_byte(tx_buf[k], 8, rx_buf[k]);
    #80;
    ss = 1'b1;
    #200;
  endtask

  task automatic start_upload(input logic [24:0] sz);
    size = sz;
    tx_buf[0] = 8'h56; tx_buf[1] = 8'h01;
    spi_txn(2);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1);
  end

  initial begin
    int         base_rd;
    logic [7:0] tmp;

    reset = 1'b1; ss = 1'b1; sck = 1'b0; sdi = 1'b0; size = '0;
    repeat (5) @(negedge clk);
    check_eq("rst_uploading", {31'd0, uploading}, 32'd0);
    check_eq("rst_index",     {27'd0, index},     32'd0);
    check_eq("rst_rd",        {31'd0, rd},        32'd0);
    check_eq("rst_a",         {7'd0, a},          {7'd0, BASE});
    check_eq("rst_sdo",       {31'd0, sdo},       32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // menu index write
    tx_buf[0] = 8'h55; tx_buf[1] = 8'h03;
    spi_txn(2);
    check_eq("idx_index",     {27'd0, index},     32'd3);
    check_eq("idx_uploading", {31'd0, uploading}, 32'd0);
    check_eq("idx_no_rd",     rd_count,           32'd0);

    // unknown command has no effect and returns zeros
    tx_buf[0] = 8'h12; tx_buf[1] = 8'h34;
    spi_txn(2);
    check_eq("unk_sdo",   {24'd0, rx_buf[1]}, 32'd0);
    check_eq("unk_index", {27'd0, index},     32'd3);

    // three-byte upload plus one byte past the end
    start_upload(25'd3);
    check_eq("up3_uploading", {31'd0, uploading}, 32'd1);
    check_eq("up3_prefetch",  rd_count,           32'd1);
    tx_buf[0] = 8'h57;
    for (int k = 1; k < 5; k++) tx_buf[k] = 8'h00;
    spi_txn(5);
    check_eq("up3_b0", {24'd0, rx_buf[1]}, 32'hA1);
    check_eq("up3_b1", {24'd0, rx_buf[2]}, 32'hB2);
    check_eq("up3_b2", {24'd0, rx_buf[3]}, 32'hC3);
    check_eq("up3_b3", {24'd0, rx_buf[4]}, 32'h00);
    check_eq("up3_rd_count", rd_count, 32'd3);
    check_eq("up3_addr0", {7'd0, rd_addrs[0]}, {7'd0, BASE});
    check_eq("up3_addr1", {7'd0, rd_addrs[1]}, {7'd0, BASE + 25'd1});
    check_eq("up3_addr2", {7'd0, rd_addrs[2]}, {7'd0, BASE + 25'd2});

    // zero-length upload
    base_rd = rd_count;
    start_upload(25'd0);
    tx_buf[0] = 8'h57; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    spi_txn(3);
    check_eq("len0_b0", {24'd0, rx_buf[1]}, 32'h00);
    check_eq("len0_b1", {24'd0, rx_buf[2]}, 32'h00);
    check_eq("len0_rd", rd_count - base_rd, 32'd0);

    // restart while uploading, then abort mid-byte and resume
    start_upload(25'd3);
    check_eq("abort_restart_addr", {7'd0, rd_addrs[rd_count-1]}, {7'd0, BASE});
    ss = 1'b0;
    #40;
    spi_byte(8'h57, 8, tmp);
    spi_byte(8'h00, 8, tmp);
    check_eq("abort_b0", {24'd0, tmp}, 32'hA1);
    spi_byte(8'h00, 4, tmp);
    check_eq("abort_partial", {24'd0, tmp}, 32'hB0);
    #80;
    ss = 1'b1;
    #200;
    check_eq("abort_uploading", {31'd0, uploading}, 32'd1);
    tx_buf[0] = 8'h57; tx_buf[1] = 8'h00;
    spi_txn(2);
    check_eq("abort_resume", {24'd0, rx_buf[1]}, 32'hC3);

    // reset in the middle of a data transaction
    start_upload(25'd3);
    tx_buf[0] = 8'h57; tx_buf[1] = 8'h00;
    spi_txn(2);
    check_eq("rstmid_b0", {24'd0, rx_buf[1]}, 32'hA1);
    ss = 1'b0;
    #40;
    spi_byte(8'h57, 8, tmp);
    spi_byte(8'h00, 3, tmp);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("rstmid_uploading", {31'd0, uploading}, 32'd0);
    check_eq("rstmid_sdo",       {31'd0, sdo},       32'd0);
    check_eq("rstmid_index",     {27'd0, index},     32'd0);
    #100;
    ss = 1'b1;
    #200;
    base_rd = rd_count;
    start_upload(25'd3);
    tx_buf[0] = 8'h57; tx_buf[1] = 8'h00;
    spi_txn(2);
    check_eq("rstmid_again_b0",   {24'd0, rx_buf[1]},          32'hA1);
    check_eq("rstmid_again_addr", {7'd0, rd_addrs[base_rd]}, {7'd0, BASE});

    // stop, then data requests return zero without reads
    size = 25'd3;
    tx_buf[0] = 8'h56; tx_buf[1] = 8'h00;
    spi_txn(2);
    check_eq("stop_uploading", {31'd0, uploading}, 32'd0);
    base_rd = rd_count;
    tx_buf[0] = 8'h57; tx_buf[1] = 8'h00;
    spi_txn(2);
    check_eq("stop_b0", {24'd0, rx_buf[1]}, 32'h00);
    check_eq("stop_rd", rd_count - base_rd, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
